// File: rtl/cb_pkg.sv
// Shared types and width helpers for the configurable connection block.
// Field widths are derived here so the loader and the top agree on the image layout.
package cb_pkg;

  typedef enum logic [1:0] {
    CB_IDLE  = 2'd0,
    CB_LOAD  = 2'd1,
    CB_READY = 2'd2
  } cb_state_e;

  localparam int SEL_NONE = 0;
  localparam int DRV_NONE = 0;

  function automatic int sel_width(input int tracks);
    return $clog2(tracks + 1);
  endfunction

  function automatic int drv_width(input int num_lb);
    return $clog2(num_lb + 1);
  endfunction

  function automatic int cfg_bits(input int num_lb, input int lb_inputs, input int tracks);
    return num_lb * lb_inputs * sel_width(tracks) + tracks * drv_width(num_lb);
  endfunction

endpackage

// File: rtl/cb_cfg_loader.sv
// Serial configuration loader: IDLE/LOAD/READY FSM, bit counter and shadow shift register.
// Exposes the shadow image, a same-cycle commit strobe, a registered done pulse and the FSM state.
module cb_cfg_loader
  import cb_pkg::*;
#(
  parameter int CFG_BITS = 34
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start_i,
  input  logic                cfg_valid_i,
  input  logic                cfg_bit_i,
  input  logic                cfg_commit_i,
  output logic [CFG_BITS-1:0] shadow_o,
  output logic                commit_o,
  output logic                done_o,
  output cb_state_e           state_o
);

  localparam int CNTW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(CFG_BITS - 1);

  cb_state_e             state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0]   shadow_q, shadow_d;
  logic                  done_q;
  logic                  commit_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CB_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= commit_s;
    end
  end

  // Start always beats a same-cycle data bit; commit beats start in READY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    commit_s = 1'b0;
    case (state_q)
      CB_IDLE: begin
        if (cfg_start_i) begin
          state_d = CB_LOAD;
          cnt_d   = '0;
        end
      end
      CB_LOAD: begin
        if (cfg_start_i) begin
          cnt_d = '0;
        end else if (cfg_valid_i) begin
          shadow_d = {cfg_bit_i, shadow_q[CFG_BITS-1:1]};
          if (cnt_q == LAST_IDX) begin
            state_d = CB_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      CB_READY: begin
        if (cfg_commit_i) begin
          commit_s = 1'b1;
          state_d  = CB_IDLE;
        end else if (cfg_start_i) begin
          state_d = CB_LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign shadow_o = shadow_q;
  assign commit_o = commit_s;
  assign done_o   = done_q;
  assign state_o  = state_q;

endmodule

// File: rtl/cfg_connection_block.sv
// Connection block between NUM_LB logic blocks and a TRACKS-wide channel.
// Binary-encoded selects from an atomically committed config drive the input and track muxes.
module cfg_connection_block
  import cb_pkg::*;
#(
  parameter int TRACKS    = 5,
  parameter int NUM_LB    = 2,
  parameter int LB_INPUTS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  input  logic                          cfg_bit,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_err,
  input  logic [NUM_LB-1:0]             lb_out,
  input  logic [TRACKS-1:0]             track_in,
  output logic [TRACKS-1:0]             track_out,
  output logic [TRACKS-1:0]             track_oe,
  output logic [NUM_LB*LB_INPUTS-1:0]   lb_in
);

  localparam int SELW     = sel_width(TRACKS);
  localparam int DRW      = drv_width(NUM_LB);
  localparam int CFG_BITS = cfg_bits(NUM_LB, LB_INPUTS, TRACKS);
  localparam int NSEL     = NUM_LB * LB_INPUTS;
  localparam int SEL_BITS = NSEL * SELW;

  logic [CFG_BITS-1:0] shadow;
  logic                commit;
  cb_state_e           state;

  logic [CFG_BITS-1:0] active_q;
  logic                err_q;
  logic                shadow_err;

  cb_cfg_loader #(
    .CFG_BITS(CFG_BITS)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .cfg_start_i  (cfg_start),
    .cfg_valid_i  (cfg_valid),
    .cfg_bit_i    (cfg_bit),
    .cfg_commit_i (cfg_commit),
    .shadow_o     (shadow),
    .commit_o     (commit),
    .done_o       (cfg_done),
    .state_o      (state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      err_q    <= 1'b0;
    end else if (commit) begin
      active_q <= shadow;
      err_q    <= shadow_err;
    end
  end

  // Error flag is computed from the shadow so it lands together with the config it describes.
  always_comb begin
    shadow_err = 1'b0;
    for (int f = 0; f < NSEL; f++) begin
      if (int'(shadow[f*SELW +: SELW]) != SEL_NONE &&
          int'(shadow[f*SELW +: SELW]) > TRACKS)
        shadow_err = 1'b1;
    end
    for (int t = 0; t < TRACKS; t++) begin
      if (int'(shadow[SEL_BITS + t*DRW +: DRW]) != DRV_NONE &&
          int'(shadow[SEL_BITS + t*DRW +: DRW]) > NUM_LB)
        shadow_err = 1'b1;
    end
  end

  always_comb begin
    lb_in = '0;
    for (int f = 0; f < NSEL; f++) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (active_q[f*SELW +: SELW] == SELW'(t + 1))
          lb_in[f] = track_in[t];
      end
    end
  end

  // Each track has a single drive field, so at most one logic block can ever drive it.
  always_comb begin
    track_out = '0;
    track_oe  = '0;
    for (int t = 0; t < TRACKS; t++) begin
      for (int l = 0; l < NUM_LB; l++) begin
        if (active_q[SEL_BITS + t*DRW +: DRW] == DRW'(l + 1)) begin
          track_oe[t]  = 1'b1;
          track_out[t] = lb_out[l];
        end
      end
    end
  end

  assign cfg_busy = (state != CB_IDLE);
  assign cfg_err  = err_q;

endmodule

// File: doc/cfg_connection_block.md
# cfg_connection_block

Parametrised connection block joining NUM_LB logic blocks to a TRACKS-wide routing channel. Configuration arrives serially, is held in a shadow chain, and is applied atomically by a commit handshake. Routing uses binary-encoded selects instead of one-hot patterns, so every configuration is legal or flagged, and no track can have two drivers. It sits between the logic-block array and the switch boxes; a top-level wrapper converts `track_out`/`track_oe` to the bidirectional channel net.

## Interface
- TRACKS, 5, routing tracks in the channel
- NUM_LB, 2, logic blocks served
- LB_INPUTS, 4, inputs per logic block
- SELW, $clog2(TRACKS+1), derived, input-select field width
- DRW, $clog2(NUM_LB+1), derived, track-drive field width
- CFG_BITS, NUM_LB*LB_INPUTS*SELW + TRACKS*DRW, derived (34 at defaults)
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- cfg_start  in  1  begin a new serial load
- cfg_valid  in  1  cfg_bit is valid this cycle
- cfg_bit  in  1  serial configuration bit
- cfg_commit  in  1  request copy of shadow into active config
- cfg_busy  out  1  load in progress or awaiting commit
- cfg_done  out  1  one-cycle pulse: commit applied
- cfg_err  out  1  active config contains an out-of-range field
- lb_out  in  NUM_LB  logic-block outputs
- track_in  in  TRACKS  resolved channel net levels
- track_out  out  TRACKS  value to drive per track
- track_oe  out  TRACKS  per-track drive enable
- lb_in  out  NUM_LB*LB_INPUTS  logic-block inputs; lb_in[b*LB_INPUTS+i]

## Operation
- Config image, LSB first: input-select fields `sel[b][i]` (index b*LB_INPUTS+i, each SELW bits), then drive fields `drv[t]` (TRACKS fields, each DRW bits).
- `sel` encoding: 0 means unconnected (lb_in=0); k in 1..TRACKS means track_in[k-1]; k>TRACKS is out of range (lb_in=0, error).
- `drv` encoding: 0 means not driven (oe=0, out=0); k in 1..NUM_LB means lb_out[k-1] with oe=1; k>NUM_LB is out of range (oe=0, error).
- Shadow is a CFG_BITS shift register. Each accepted bit enters at the MSB and the register shifts right. After CFG_BITS bits, the first bit sent sits at bit 0.
- FSM IDLE / LOAD / READY:
  - IDLE: cfg_start clears the bit counter and goes to LOAD. cfg_valid and cfg_commit are ignored.
  - LOAD: cfg_valid shifts cfg_bit and increments the counter. On the accept of bit CFG_BITS-1, go to READY. cfg_start restarts the load (counter=0). cfg_commit is ignored.
  - READY: cfg_valid is ignored. cfg_commit copies shadow to active, sets cfg_err from the shadow contents, pulses cfg_done, and goes to IDLE. cfg_start alone restarts the load. If cfg_commit and cfg_start arrive together, commit wins and start is dropped.
- cfg_start with cfg_valid in the same cycle: start takes effect and the bit is not captured.
- cfg_busy = (state != IDLE).
- Routing is combinational from the active config. The active config changes only at commit, so routing never shows a partial load.
- cfg_err holds until the next commit and describes the active config.

## Timing
- Reset: state=IDLE, counter=0, shadow=0, active=0. Outputs: lb_in=0, track_out=0, track_oe=0, cfg_busy=0, cfg_done=0, cfg_err=0.
- Reset during LOAD or READY discards the partial load and clears the active config.
- Load takes exactly CFG_BITS accepted bits. Gaps in cfg_valid are allowed.
- Commit sampled at edge N: the active config and cfg_err update at edge N. cfg_done is high and new routing is visible in cycle N+1. cfg_busy is low in cycle N+1.
- Routing latency from lb_out/track_in to track_out/lb_in: 0 cycles (combinational).
- The counter is CFG_BITS-bit-index wide and must not wrap, because the FSM leaves LOAD at the last bit.

## Structure
- Package `cb_pkg`: state enum (CB_IDLE, CB_LOAD, CB_READY), SEL_NONE=0, DRV_NONE=0, width-calc functions for SELW/DRW/CFG_BITS.
- Sub-module `cb_cfg_loader`: FSM, counter, shadow shift register, commit pulse. It exports the shadow vector and the commit strobe.
- Top: active register, per-input select muxes, per-track drive muxes, range checker.

## Test plan
- Reset then idle: all outputs 0; cfg_valid/cfg_commit in IDLE leave the active config unchanged.
- Load sel[0][0]=3, sel[1][2]=5, drv[1]=1, drv[4]=2, rest 0, then commit: cfg_done pulses 1 cycle; lb_in[0]=track_in[2], lb_in[6]=track_in[4]; track_oe=5'b10010, track_out[1]=lb_out[0], track_out[4]=lb_out[1]; cfg_err=0.
- Load sel[0][1]=7 and drv[0]=3, then commit: lb_in[1]=0, track_oe[0]=0, cfg_err=1. A subsequent legal commit clears cfg_err.
- Commit asserted in LOAD after 20 bits: ignored, active config unchanged. Finish the remaining 14 bits and commit: new config applied.
- Reset asserted after 10 bits of a load following a valid commit: active config cleared, state IDLE, cfg_busy=0.
- In READY, cfg_commit and cfg_start in the same cycle: commit applied, cfg_done=1, state IDLE. cfg_start with cfg_valid in LOAD: counter=0, that bit dropped.
